uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 77 +++++++
 rtl/uart_tx_feeder.sv | 117 +++++++++++
 tb/tb_uart_tx_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and FSM state encoding.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags and a head-of-queue read port.
// A write is accepted when there is room or when a read happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wr_rejected
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             rd_accept;
    logic             wr_accept;

    assign rd_accept   = rd_en && !empty_q;
    assign wr_accept   = wr_en && (!full_q || rd_accept);
    assign wr_rejected = wr_en && !wr_accept;

    always_comb begin
        count_d = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset so it maps onto plain RAM; pointers/flags do.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and hands them one at a time to a byte transmitter (send_en/tx_done handshake),
// optionally idling GAP_CYCLES between bytes. Sticky overflow flag under UART_TX_FEEDER_OVF_FLAG_EN.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [UART_BYTE_W-1:0]   wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [UART_BYTE_W-1:0]   data_byte,
    output logic                     send_en,
    input  logic                     tx_done,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    tx_state_e              state_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [UART_BYTE_W-1:0] data_byte_q;
    logic                   send_en_q;
    logic [UART_BYTE_W-1:0] head_byte;
    logic                   pop;
    logic                   wr_rejected;

    assign pop = (state_q == IDLE) && !empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (pop),
        .rd_data     (head_byte),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .wr_rejected (wr_rejected)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            data_byte_q <= '0;
            send_en_q   <= 1'b0;
        end else begin
            send_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        data_byte_q <= head_byte;
                        send_en_q   <= 1'b1;
                        state_q     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (GAP_CYCLES > 0) begin
                            // Loaded with GAP_CYCLES-1 so GAP occupies exactly GAP_CYCLES cycles.
                            gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                            state_q   <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_byte = data_byte_q;
    assign send_en   = send_en_q;

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    logic overflow_q;

    // A rejected write in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (wr_rejected) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf_inputs;

    assign unused_ovf_inputs = ovf_clr ^ wr_rejected;
    assign overflow          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder (DEPTH=16, GAP_CYCLES=3 main instance, GAP_CYCLES=0 side instance).
module tb_uart_tx_feeder;

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, tx_done, ovf_clr;
    logic [7:0] wr_data;
    logic       full, empty, send_en, overflow;
    logic [4:0] count;
    logic [7:0] data_byte;

    logic       b_wr_en, b_tx_done, b_ovf_clr;
    logic [7:0] b_wr_data;
    logic       b_full, b_empty, b_send_en, b_overflow;
    logic [4:0] b_count;
    logic [7:0] b_data_byte;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .data_byte(data_byte),
        .send_en(send_en), .tx_done(tx_done), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .full(b_full), .empty(b_empty), .count(b_count), .data_byte(b_data_byte),
        .send_en(b_send_en), .tx_done(b_tx_done), .overflow(b_overflow), .ovf_clr(b_ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse tx_done, then expect the next send_en exactly 4 edges later (3 GAP + 1 IDLE pop).
    task automatic release_and_expect(input logic [7:0] exp, input string tag);
        int  k;
        bit  seen;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            tick();
            k++;
            if (send_en) seen = 1'b1;
        end
        chk({tag, "_latency"}, k, 4);
        chk({tag, "_data"}, data_byte, exp);
        $display("tx byte %s: data=0x%02h latency=%0d", tag, data_byte, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0; ovf_clr = 1'b0;
        b_wr_en = 1'b0; b_wr_data = 8'h00; b_tx_done = 1'b0; b_ovf_clr = 1'b0;
        repeat (2) tick();

        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_send_en", send_en, 0);
        chk("rst_data_byte", data_byte, 8'h00);
        chk("rst_overflow", overflow, 0);
        $display("reset state: empty=%0b full=%0b count=%0d", empty, full, count);
        reset = 1'b0;
        tick();

        // tx_done in IDLE has no effect
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_txdone_ignored", send_en, 0);

        // Single byte: write at edge N, send_en between N+1 and N+2
        wr_en = 1'b1; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("aa_count_after_write", count, 1);
        chk("aa_no_send_yet", send_en, 0);
        tick();
        chk("aa_send_en", send_en, 1);
        chk("aa_data_byte", data_byte, 8'hAA);
        chk("aa_popped_empty", empty, 1);
        $display("write 0xAA: send_en=%0b data_byte=0x%02h", send_en, data_byte);

        // Queue a second byte; nothing is issued until tx_done
        wr_en = 1'b1; wr_data = 8'hBB;
        tick();
        wr_en = 1'b0;
        chk("aa_send_one_cycle", send_en, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_send_before_done", send_en, 0);
        end
        chk("bb_queued_count", count, 1);
        chk("aa_data_stable", data_byte, 8'hAA);

        // tx_done -> 3 GAP cycles (tx_done in GAP ignored) -> second byte
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("gap_e0", send_en, 0);
        tick();
        chk("gap_e1", send_en, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("gap_e2", send_en, 0);
        tick();
        chk("gap_e3", send_en, 0);
        tick();
        chk("bb_send_after_gap", send_en, 1);
        chk("bb_data_byte", data_byte, 8'hBB);
        $display("gap test: second byte 0x%02h sent 4 edges after tx_done", data_byte);

        // Burst 01..10 while BB is in flight: FIFO fills
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            if (i == 15) begin
                chk("burst15_full", full, 0);
                chk("burst15_count", count, 15);
            end
        end
        wr_en = 1'b0;
        chk("burst16_full", full, 1);
        chk("burst16_count", count, 16);
        chk("burst_no_send", send_en, 0);
        $display("burst 01..10: count=%0d full=%0b", count, full);

        // Write while full without pop is dropped
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        chk("ovf_write_dropped_count", count, 16);
        chk("ovf_flag_set", overflow, OVF_ON);
        repeat (3) tick();
        chk("ovf_flag_sticky", overflow, OVF_ON);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_flag_cleared", overflow, 0);
        wr_en = 1'b1; wr_data = 8'h78; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", overflow, OVF_ON);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared_again", overflow, 0);
        $display("overflow test: flag enabled=%0b", OVF_ON);

        // Full FIFO: write lands on the same edge as the pop of 01
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (2) tick();
        tick();
        chk("full_pop_pre_send", send_en, 0);
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        chk("full_pop_send", send_en, 1);
        chk("full_pop_data", data_byte, 8'h01);
        chk("full_pop_count", count, 16);
        chk("full_pop_full", full, 1);
        chk("full_pop_no_ovf", overflow, 0);
        $display("write+pop at full: count=%0d data_byte=0x%02h", count, data_byte);

        // Drain and confirm order 02..10 then 11
        for (int i = 2; i <= 17; i++) begin
            release_and_expect((i <= 16) ? 8'(i) : 8'h11, $sformatf("drain%0d", i));
        end
        chk("drained_empty", empty, 1);
        chk("drained_count", count, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_send_after_drain", send_en, 0);
        end

        // Reset while in WAIT_DONE with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h21 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_reset_count", count, 5);
        chk("pre_reset_data", data_byte, 8'h21);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_send_en", send_en, 0);
        chk("async_rst_data", data_byte, 8'h00);
        $display("mid-byte reset: count=%0d empty=%0b", count, empty);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tx_done = (i == 2);
            tick();
            chk("no_send_after_reset", send_en, 0);
        end
        tx_done = 1'b0;
        chk("post_reset_empty", empty, 1);

        // GAP_CYCLES=0 instance: next byte issued one edge after tx_done
        b_wr_en = 1'b1; b_wr_data = 8'hA1;
        tick();
        b_wr_data = 8'hA2;
        tick();
        b_wr_en = 1'b0;
        chk("nogap_first_send", b_send_en, 1);
        chk("nogap_first_data", b_data_byte, 8'hA1);
        chk("nogap_count", b_count, 1);
        tick();
        chk("nogap_send_drop", b_send_en, 0);
        b_tx_done = 1'b1;
        tick();
        b_tx_done = 1'b0;
        chk("nogap_done_edge", b_send_en, 0);
        tick();
        chk("nogap_second_send", b_send_en, 1);
        chk("nogap_second_data", b_data_byte, 8'hA2);
        $display("no-gap instance: second byte 0x%02h", b_data_byte);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
